// File: rtl/inst_timing.sv
// Instruction timing controller: decodes each fetched opcode into a cycle count, adds
// page-cross and branch penalties, and signals next_sync on the final cycle of each instruction.
module inst_timing #(
  parameter logic [7:0]  RESET_OPCODE = 8'hEA,
  parameter int unsigned ILLEGAL_LEN  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] cycle,
  input  logic       sync,
  input  logic [7:0] data_in,
  input  logic       page_cross,
  input  logic       branch_taken,
  output logic       next_sync,
  output logic [7:0] opcode,
  output logic [2:0] tstate,
  output logic       illegal
);

  localparam logic [1:0] CL_FIX = 2'd0;
  localparam logic [1:0] CL_RD  = 2'd1;
  localparam logic [1:0] CL_BR  = 2'd2;

  // Returns {illegal, class, base length}; CL_RD adds the page-cross penalty to base.
  function automatic logic [5:0] decode(input logic [7:0] op);
    logic [2:0] aaa, bbb, base;
    logic [1:0] cc, cl;
    logic       ill, xy;
    aaa  = op[7:5];
    bbb  = op[4:2];
    cc   = op[1:0];
    xy   = (aaa == 3'd4) || (aaa == 3'd5);
    ill  = 1'b0;
    cl   = CL_FIX;
    base = 3'd2;
    case (cc)
      2'b01: case (bbb)
        3'd0: base = 3'd6;
        3'd1: base = 3'd3;
        3'd2: ill = (aaa == 3'd4);
        3'd3: base = 3'd4;
        3'd4: if (aaa == 3'd4) base = 3'd6; else begin base = 3'd5; cl = CL_RD; end
        3'd5: base = 3'd4;
        default: if (aaa == 3'd4) base = 3'd5; else begin base = 3'd4; cl = CL_RD; end
      endcase
      2'b10: case (bbb)
        3'd0: ill = (aaa != 3'd5);
        3'd1: base = xy ? 3'd3 : 3'd5;
        3'd2: base = 3'd2;
        3'd3: base = xy ? 3'd4 : 3'd6;
        3'd4: ill = 1'b1;
        3'd5: base = xy ? 3'd4 : 3'd6;
        3'd6: ill = !xy;
        default: begin
          if (aaa == 3'd5) begin base = 3'd4; cl = CL_RD; end
          else if (aaa == 3'd4) ill = 1'b1;
          else base = 3'd7;
        end
      endcase
      2'b00: case (bbb)
        3'd0: case (aaa)
          3'd0:                base = 3'd7;
          3'd1, 3'd2, 3'd3:    base = 3'd6;
          3'd4:                ill  = 1'b1;
          default:             base = 3'd2;
        endcase
        3'd1: begin ill = (aaa == 3'd0) || (aaa == 3'd2) || (aaa == 3'd3); base = 3'd3; end
        3'd2: case (aaa)
          3'd0, 3'd2: base = 3'd3;
          3'd1, 3'd3: base = 3'd4;
          default:    base = 3'd2;
        endcase
        3'd3: case (aaa)
          3'd0:    ill  = 1'b1;
          3'd2:    base = 3'd3;
          3'd3:    base = 3'd5;
          default: base = 3'd4;
        endcase
        3'd4: cl = CL_BR;
        3'd5: begin ill = !xy; base = 3'd4; end
        3'd6: base = 3'd2;
        default: if (aaa == 3'd5) begin base = 3'd4; cl = CL_RD; end else ill = 1'b1;
      endcase
      default: ill = 1'b1;
    endcase
    return {ill, cl, base};
  endfunction

  localparam logic [5:0] RESET_DEC = decode(RESET_OPCODE);

  logic [7:0] opcode_q, opcode_d;
  logic [5:0] dec_q, dec_d;
  logic       ext_q, ext_d;
  logic       pc_flag_q, pc_flag_d;
  logic       taken_q, taken_d;

  logic [2:0] t_c, len_c, pc_min_c;
  logic       fetch_c, pc_now_c, eff_pc_c, taken_c, ns_c, is_br_c;

  always_comb begin
    t_c = 3'd0;
    if (ext_q) begin
      t_c = 3'd7;
    end else begin
      for (int i = 5; i >= 0; i--) begin
        if (cycle[i]) t_c = 3'(i + 1);
      end
    end
  end

  // Branches only count a page cross from T3, after the taken target is formed.
  always_comb begin
    is_br_c  = (dec_q[4:3] == CL_BR);
    pc_min_c = is_br_c ? 3'd3 : 3'd2;
    pc_now_c = page_cross && (t_c >= pc_min_c);
    eff_pc_c = pc_flag_q || pc_now_c;
    taken_c  = taken_q || (branch_taken && (t_c == 3'd2));
    case (dec_q[4:3])
      CL_RD:   len_c = dec_q[2:0] + {2'b00, eff_pc_c};
      CL_BR:   len_c = taken_c ? (3'd3 + {2'b00, eff_pc_c}) : 3'd2;
      default: len_c = dec_q[2:0];
    endcase
    if (dec_q[5]) len_c = 3'(ILLEGAL_LEN);
  end

  always_comb begin
    if ((t_c == 3'd0) || (t_c == 3'd7)) ns_c = 1'b1;
    else if (t_c == 3'd1)                ns_c = 1'b0;
    else                                 ns_c = (t_c == len_c);
  end

  always_comb begin
    fetch_c   = sync && cycle[0];
    opcode_d  = opcode_q;
    dec_d     = dec_q;
    ext_d     = !ns_c && (ext_q || cycle[5]);
    pc_flag_d = pc_flag_q || pc_now_c;
    taken_d   = taken_c;
    if (fetch_c) begin
      opcode_d  = data_in;
      dec_d     = decode(data_in);
      ext_d     = 1'b0;
      pc_flag_d = 1'b0;
      taken_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q  <= RESET_OPCODE;
      dec_q     <= RESET_DEC;
      ext_q     <= 1'b0;
      pc_flag_q <= 1'b0;
      taken_q   <= 1'b0;
    end else begin
      opcode_q  <= opcode_d;
      dec_q     <= dec_d;
      ext_q     <= ext_d;
      pc_flag_q <= pc_flag_d;
      taken_q   <= taken_d;
    end
  end

  assign next_sync = reset || ns_c;
  assign opcode    = opcode_q;
  assign tstate    = t_c;
  assign illegal   = dec_q[5];

endmodule

// File: tb/tb_inst_timing.sv
// Directed bench for inst_timing: the bench plays the sequencer, stepping the one-hot
// cycle vector itself and checking tstate/next_sync against hand-derived instruction lengths.
module tb_inst_timing;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] cycle;
  logic       sync;
  logic [7:0] data_in;
  logic       page_cross;
  logic       branch_taken;
  logic       next_sync;
  logic [7:0] opcode;
  logic [2:0] tstate;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_timing dut (
    .clk          (clk),
    .reset        (reset),
    .cycle        (cycle),
    .sync         (sync),
    .data_in      (data_in),
    .page_cross   (page_cross),
    .branch_taken (branch_taken),
    .next_sync    (next_sync),
    .opcode       (opcode),
    .tstate       (tstate),
    .illegal      (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle k of an instruction: k=1..6 one-hot, k=7 all-zero (extended cycle).
  task automatic drive(input int k, input logic [7:0] op, input int pc_t, input logic tk,
                       input logic glitch);
    cycle        = (k >= 1 && k <= 6) ? 6'(1 << (k - 1)) : 6'd0;
    sync         = (k == 1) || (glitch && k == 2);
    data_in      = (k == 1) ? op : 8'h00;
    page_cross   = (k == pc_t);
    branch_taken = tk && (k == 2);
  endtask

  task automatic run_instr(input string tag, input logic [7:0] op, input int pc_t,
                           input logic tk, input int last, input logic ill, input logic glitch);
    for (int k = 1; k <= last; k++) begin
      drive(k, op, pc_t, tk, glitch);
      #1;
      chk($sformatf("%s_t%0d", tag, k), 32'(tstate), 32'(k));
      chk($sformatf("%s_ns%0d", tag, k), 32'(next_sync), 32'(k == last));
      @(negedge clk);
    end
    chk($sformatf("%s_op", tag), 32'(opcode), 32'(op));
    chk($sformatf("%s_ill", tag), 32'(illegal), 32'(ill));
  endtask

  initial begin
    reset = 1'b1; cycle = 6'd0; sync = 1'b0; data_in = 8'h00;
    page_cross = 1'b0; branch_taken = 1'b0;
    #1;
    chk("rst_ns",  32'(next_sync), 32'd1);
    chk("rst_op",  32'(opcode),    32'hEA);
    chk("rst_ill", 32'(illegal),   32'd0);
    chk("rst_t",   32'(tstate),    32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_instr("lda_imm",   8'hA9, 0, 1'b0, 2, 1'b0, 1'b0);
    run_instr("lda_absx",  8'hBD, 0, 1'b0, 4, 1'b0, 1'b0);
    run_instr("lda_pc3",   8'hBD, 3, 1'b0, 5, 1'b0, 1'b0);
    run_instr("lda_pc4",   8'hBD, 4, 1'b0, 5, 1'b0, 1'b0);
    run_instr("lda_indy",  8'hB1, 4, 1'b0, 6, 1'b0, 1'b0);
    run_instr("asl_absx",  8'h1E, 0, 1'b0, 7, 1'b0, 1'b0);
    run_instr("bne_nt",    8'hD0, 0, 1'b0, 2, 1'b0, 1'b0);
    run_instr("bne_tk",    8'hD0, 0, 1'b1, 3, 1'b0, 1'b0);
    run_instr("bne_pc3",   8'hD0, 3, 1'b1, 4, 1'b0, 1'b0);
    run_instr("bne_pc2",   8'hD0, 2, 1'b1, 3, 1'b0, 1'b0);
    run_instr("sta_absx",  8'h9D, 3, 1'b0, 5, 1'b0, 1'b0);
    run_instr("illegal02", 8'h02, 0, 1'b0, 2, 1'b1, 1'b0);
    run_instr("sync_nocap", 8'hBD, 0, 1'b0, 4, 1'b0, 1'b1);

    // JSR aborted by reset in T4
    for (int k = 1; k <= 3; k++) begin
      drive(k, 8'h20, 0, 1'b0, 1'b0);
      #1;
      chk($sformatf("jsr_t%0d", k), 32'(tstate), 32'(k));
      chk($sformatf("jsr_ns%0d", k), 32'(next_sync), 32'd0);
      @(negedge clk);
    end
    drive(4, 8'h20, 0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("jsr_rst_ns", 32'(next_sync), 32'd1);
    chk("jsr_rst_op", 32'(opcode),    32'hEA);
    @(negedge clk);
    drive(1, 8'hFF, 0, 1'b0, 1'b0);
    #1;
    chk("rst_nocap_op", 32'(opcode), 32'hEA);
    @(negedge clk);
    reset = 1'b0;
    run_instr("rts", 8'h60, 0, 1'b0, 6, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
